dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's data interface (addr/wr/mask/write-data/rd out, valid/read-data in).
- Accepts one load or store at a time and holds it for a programmable number of wait cycles.
- Commits byte-masked stores and returns full 32-bit words on loads, signalling completion with a one-cycle valid pulse.
- Sits between the core and on-chip data RAM; byte/half extraction and sign extension remain in the core.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: data-memory target; one load/store at a time, LATENCY wait cycles, one-cycle valid pulse.
// Optional macro DMEM_BOUNDS_CHECK_EN adds op_data_err and blocks out-of-range accesses. Revision 1.0
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        op_data_err
`endif
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  wr_q;
  logic                  rd_q;
  logic                  oob_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic                  accept;
  logic                  commit;
  logic                  in_oob;
  logic [ADDR_WIDTH-1:0] sel_idx;
  logic                  sel_wr;
  logic                  sel_rd;
  logic                  sel_oob;
  logic [3:0]            sel_mask;
  logic [31:0]           sel_wdata;

  assign req    = ip_data_rd | ip_data_wr;
  assign accept = (state == IDLE) && req;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic unused_addr_bits;
  assign in_oob           = |ip_data_addr[31:ADDR_WIDTH+2];
  assign unused_addr_bits = ^ip_data_addr[1:0];
`else
  logic unused_addr_bits;
  assign in_oob           = 1'b0;
  assign unused_addr_bits = ^{ip_data_addr[31:ADDR_WIDTH+2], ip_data_addr[1:0]};
`endif

  // With zero latency the commit happens on the acceptance edge, so it must use the port values directly.
  assign sel_idx   = (state == IDLE) ? ip_data_addr[ADDR_WIDTH+1:2] : idx_q;
  assign sel_wr    = (state == IDLE) ? ip_data_wr        : wr_q;
  assign sel_rd    = (state == IDLE) ? ip_data_rd        : rd_q;
  assign sel_oob   = (state == IDLE) ? in_oob            : oob_q;
  assign sel_mask  = (state == IDLE) ? ip_data_mask      : mask_q;
  assign sel_wdata = (state == IDLE) ? ip_data_from_proc : wdata_q;

  assign commit = reset_n &&
                  ((accept && (LAT == 4'd0)) || ((state == WAIT) && (count == 4'd1)));

  always_ff @(posedge clk) begin
    if (commit && sel_wr && !sel_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_mask[i]) begin
          mem[sel_idx][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      count           <= 4'd0;
      op_data_valid   <= 1'b0;
      op_data_to_proc <= 32'd0;
`ifdef DMEM_BOUNDS_CHECK_EN
      op_data_err     <= 1'b0;
`endif
    end else begin
      op_data_valid <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
      op_data_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= ip_data_addr[ADDR_WIDTH+1:2];
            wr_q    <= ip_data_wr;
            rd_q    <= ip_data_rd;
            oob_q   <= in_oob;
            mask_q  <= ip_data_mask;
            wdata_q <= ip_data_from_proc;
            count   <= LAT;
            state   <= (LAT == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Read sees the pre-write word, giving read-before-write on combined rd+wr.
      if (commit) begin
        op_data_valid <= 1'b1;
        if (sel_rd) begin
          op_data_to_proc <= sel_oob ? 32'd0 : mem[sel_idx];
        end
`ifdef DMEM_BOUNDS_CHECK_EN
        op_data_err <= sel_oob;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: three responders (LATENCY 0, 1, 4) on shared stimulus, checked every cycle against a transaction-level model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [3:0]  mask;
  logic [2:0]  valid;
  logic [31:0] rdata [3];
`ifdef DMEM_BOUNDS_CHECK_EN
  logic [2:0]  err;
  localparam bit         OOB_EN    = 1'b1;
  localparam bit [31:0]  ALIAS_EXP = 32'h13572468;
  localparam bit [31:0]  HIGH_EXP  = 32'h0;
`else
  localparam bit         OOB_EN    = 1'b0;
  localparam bit [31:0]  ALIAS_EXP = 32'h55AA55AA;
  localparam bit [31:0]  HIGH_EXP  = 32'h55AA55AA;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   ((g == 0) ? 0 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ip_data_addr     (addr),
      .ip_data_wr       (wr),
      .ip_data_mask     (mask),
      .ip_data_from_proc(wdata),
      .ip_data_rd       (rd),
      .op_data_valid    (valid[g]),
      .op_data_to_proc  (rdata[g])
`ifdef DMEM_BOUNDS_CHECK_EN
      ,
      .op_data_err      (err[g])
`endif
    );
  end

  int lats[3] = '{0, 1, 4};
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Transaction-level model: each DUT serves one request at a time; word store keyed by dut*4096+index.
  int        free_c [3];
  int        commit_c [3];
  int        pend_c [3];
  bit        p_wr [3];
  bit        p_rd [3];
  bit        p_oob [3];
  int        p_idx [3];
  bit [3:0]  p_mask [3];
  bit [31:0] p_data [3];
  bit [31:0] last [3];
  bit        known [3];
  int        pulses [3];
  bit [31:0] mm [int];

  function automatic bit is_oob(logic [31:0] a);
    return OOB_EN && (a[31:12] != 20'd0);
  endfunction

  task automatic cmp(string name, int k, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        pend_c[k]   = -1;
        commit_c[k] = -1;
        free_c[k]   = cyc + 1;
        last[k]     = 32'd0;
        known[k]    = 1'b1;
      end else begin
        if (cyc >= free_c[k] && (rd || wr)) begin
          p_wr[k]     = wr;
          p_rd[k]     = rd;
          p_oob[k]    = is_oob(addr);
          p_idx[k]    = int'(addr[11:2]);
          p_mask[k]   = mask;
          p_data[k]   = wdata;
          commit_c[k] = cyc + lats[k];
          pend_c[k]   = cyc + 1 + lats[k];
          free_c[k]   = cyc + lats[k] + 2;
        end
        if (commit_c[k] == cyc) begin
          int key = k * 4096 + p_idx[k];
          if (p_rd[k]) begin
            if (p_oob[k]) begin
              last[k] = 32'd0; known[k] = 1'b1;
            end else if (mm.exists(key)) begin
              last[k] = mm[key]; known[k] = 1'b1;
            end else begin
              known[k] = 1'b0;
            end
          end
          if (p_wr[k] && !p_oob[k]) begin
            if (mm.exists(key)) begin
              bit [31:0] w = mm[key];
              for (int b = 0; b < 4; b++)
                if (p_mask[k][b]) w[8*b +: 8] = p_data[k][8*b +: 8];
              mm[key] = w;
            end else if (p_mask[k] == 4'hF) begin
              mm[key] = p_data[k];
            end
          end
        end
      end
    end
  endtask

  task automatic check();
    for (int k = 0; k < 3; k++) begin
      bit ev = (pend_c[k] == cyc);
      cmp("valid", k, {31'd0, valid[k]}, {31'd0, ev});
      if (valid[k] === 1'b1) pulses[k]++;
      if (known[k]) cmp("rdata", k, rdata[k], last[k]);
`ifdef DMEM_BOUNDS_CHECK_EN
      cmp("err", k, {31'd0, err[k]}, {31'd0, ev && p_oob[k]});
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check();
  endtask

  task automatic idle(int n);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic one_req(bit r, bit w, logic [31:0] a, logic [3:0] m, logic [31:0] d);
    rd = r; wr = w; addr = a; mask = m; wdata = d;
    tick();
    idle(7);
  endtask

  typedef struct {
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [3:0]  mask;
    bit [31:0] wdata;
    bit        chk;
    bit [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int base [3];
    int exp_held [3] = '{5, 3, 2};
    int exp_rst [3]  = '{1, 1, 0};
    bit [31:0] exp_ld [3] = '{32'h0BADF00D, 32'h0BADF00D, 32'h0};

    tbl[0]  = '{0, 1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h10,   4'h0, 32'h0,        1, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 32'h10,   4'h4, 32'h11223344, 0, 32'h0};
    tbl[3]  = '{1, 0, 32'h10,   4'h0, 32'h0,        1, 32'hDE22BEEF};
    tbl[4]  = '{0, 1, 32'h10,   4'h0, 32'hFFFFFFFF, 0, 32'h0};
    tbl[5]  = '{1, 0, 32'h10,   4'h0, 32'h0,        1, 32'hDE22BEEF};
    tbl[6]  = '{0, 1, 32'h20,   4'hF, 32'h01234567, 0, 32'h0};
    tbl[7]  = '{1, 0, 32'h22,   4'h0, 32'h0,        1, 32'h01234567};
    tbl[8]  = '{1, 1, 32'h20,   4'hF, 32'hCAFEF00D, 1, 32'h01234567};
    tbl[9]  = '{1, 0, 32'h20,   4'h0, 32'h0,        1, 32'hCAFEF00D};
    tbl[10] = '{0, 1, 32'h04,   4'hF, 32'h13572468, 0, 32'h0};
    tbl[11] = '{0, 1, 32'h1004, 4'hF, 32'h55AA55AA, 0, 32'h0};
    tbl[12] = '{1, 0, 32'h04,   4'h0, 32'h0,        1, ALIAS_EXP};
    tbl[13] = '{1, 0, 32'h1004, 4'h0, 32'h0,        1, HIGH_EXP};
    tbl[14] = '{0, 1, 32'h40,   4'hF, 32'h0,        0, 32'h0};
    tbl[15] = '{1, 0, 32'h40,   4'h0, 32'h0,        1, 32'h0};

    for (int k = 0; k < 3; k++) begin
      pend_c[k] = -1; commit_c[k] = -1; free_c[k] = 0; known[k] = 1'b0; pulses[k] = 0;
    end
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; mask = '0; wdata = '0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      cmp("reset_valid", k, {31'd0, valid[k]}, 32'd0);
      cmp("reset_rdata", k, rdata[k], 32'd0);
    end
    reset_n = 1'b1;
    idle(20);
    for (int k = 0; k < 3; k++) cmp("idle_pulses", k, pulses[k], 0);

    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 3; k++) base[k] = pulses[k];
      one_req(tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].mask, tbl[v].wdata);
      for (int k = 0; k < 3; k++) begin
        cmp("vec_pulses", k, pulses[k] - base[k], 1);
        if (tbl[v].chk) cmp("vec_rdata", k, rdata[k], tbl[v].exp);
      end
    end

    // Read held high: each responder re-accepts as soon as it returns to idle.
    for (int k = 0; k < 3; k++) base[k] = pulses[k];
    rd = 1'b1; wr = 1'b0; addr = 32'h20;
    for (int i = 0; i < 9; i++) tick();
    idle(7);
    for (int k = 0; k < 3; k++) begin
      cmp("held_pulses", k, pulses[k] - base[k], exp_held[k]);
      cmp("held_rdata", k, rdata[k], 32'hCAFEF00D);
    end

    // Reset two cycles after accepting a store: only the LATENCY=4 responder has not committed.
    for (int k = 0; k < 3; k++) base[k] = pulses[k];
    rd = 1'b0; wr = 1'b1; addr = 32'h40; mask = 4'hF; wdata = 32'h0BADF00D;
    tick();
    wr = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    idle(7);
    for (int k = 0; k < 3; k++) cmp("rst_pulses", k, pulses[k] - base[k], exp_rst[k]);
    one_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) cmp("rst_load", k, rdata[k], exp_ld[k]);

    for (int w = 0; w < 16; w++) one_req(1'b0, 1'b1, w * 4, 4'hF, $urandom);

    for (int t = 0; t < 150; t++) begin
      int sel  = $urandom_range(0, 2);
      int hold = $urandom_range(1, 8);
      rd    = (sel != 1);
      wr    = (sel != 0);
      addr  = ($urandom_range(0, 3) == 0 ? 32'h1000 : 32'h0) |
              (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      mask  = 4'($urandom);
      wdata = $urandom;
      for (int i = 0; i < hold; i++) begin
        reset_n = ($urandom_range(0, 39) != 0);
        tick();
      end
      reset_n = 1'b1;
      idle($urandom_range(0, 3));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
